button_switch_avmm_slave: RTL and testbench

- Avalon-MM responder (slave) that lets the Nios/Qsys system master read the board pushbuttons and toggle switches.
- Synchronises and debounces ORG_BUTTON and SW, latches button press edges and raises an interrupt.
- Instantiated at top level beside the Qsys system, wired to an exported Avalon-MM slave port plus an IRQ line.

---
 rtl/button_switch_avmm_slave_if.sv | 19 +
 rtl/button_switch_avmm_slave.sv | 97 +++++++++
 tb/tb_button_switch_avmm_slave.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/button_switch_avmm_slave_if.sv
// Avalon-MM slave port plus level interrupt line for the button/switch responder.
interface button_switch_avmm_slave_if;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, irq
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, irq
    );
endinterface

// File: rtl/button_switch_avmm_slave.sv
// Debounced pushbutton/switch reader with press-edge latching, interrupt mask,
// and a 4-word Avalon-MM register map (STATUS, EDGE W1C, MASK, ID).
module button_switch_avmm_slave #(
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          CNT_W           = 19,
    parameter logic [31:0] ID_VALUE        = 32'h0DE0_0001
) (
    input  logic                            clk_clk,
    input  logic                            reset_reset_n,
    input  logic [2:0]                      ORG_BUTTON,
    input  logic [9:0]                      SW,
    button_switch_avmm_slave_if.slave       avs
);
    localparam int NB = 13;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit layout of every per-input vector: [9:0] switches, [12:10] buttons (1 = pressed).
    logic [NB-1:0]            raw;
    logic [NB-1:0]            sync1_q, sync2_q;
    logic [NB-1:0]            stable_q, stable_d;
    logic [NB-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]               edge_q, edge_d;
    logic [2:0]               mask_q, mask_d;
    logic [2:0]               press;
    logic [31:0]              rdata_q, rdata_d;
    logic                     irq_q, irq_d;
    logic                     unused_wdata;

    assign raw          = {~ORG_BUTTON, SW};
    assign unused_wdata = ^avs.avs_writedata[31:3];

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < NB; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end

        press = stable_d[12:10] & ~stable_q[12:10];

        // A new press on the same bit as a W1C clear must survive, so OR it in last.
        edge_d = edge_q;
        if (avs.avs_write && avs.avs_address == 2'd1) begin
            edge_d = edge_q & ~avs.avs_writedata[2:0];
        end
        edge_d = edge_d | press;

        mask_d = mask_q;
        if (avs.avs_write && avs.avs_address == 2'd2) begin
            mask_d = avs.avs_writedata[2:0];
        end

        rdata_d = rdata_q;
        if (avs.avs_read) begin
            case (avs.avs_address)
                2'd0:    rdata_d = {13'b0, stable_q[12:10], 6'b0, stable_q[9:0]};
                2'd1:    rdata_d = {29'b0, edge_q};
                2'd2:    rdata_d = {29'b0, mask_q};
                default: rdata_d = ID_VALUE;
            endcase
        end

        irq_d = |(edge_q & mask_q);
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            edge_q   <= '0;
            mask_q   <= '0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            edge_q   <= edge_d;
            mask_q   <= mask_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    assign avs.avs_readdata = rdata_q;
    assign avs.irq          = irq_q;
endmodule

// File: tb/tb_button_switch_avmm_slave.sv
// Directed plus randomized bench for button_switch_avmm_slave with a short debounce.
module tb_button_switch_avmm_slave;
    localparam int D = 4;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n;
    logic [2:0] ORG_BUTTON;
    logic [9:0] SW;
    logic [31:0] rd;

    int n_cmp = 0;
    int n_err = 0;

    button_switch_avmm_slave_if bus ();

    button_switch_avmm_slave #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3),
        .ID_VALUE       (32'h0DE0_0001)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .ORG_BUTTON   (ORG_BUTTON),
        .SW           (SW),
        .avs          (bus)
    );

    always #5 clk_clk = ~clk_clk;

    // Reference model: a stable bit flips once the last D synchronised samples
    // (each being the raw input two clocks earlier) all disagree with it.
    logic [12:0] raw_dly[$];
    logic [12:0] syn_hist[$];
    logic [12:0] m_stable;
    logic [2:0]  m_edge, m_mask;
    logic [31:0] m_rdata;
    logic        m_irq;

    task automatic model_step();
        logic [12:0] synced, nxt;
        logic [2:0]  pr;
        bit          all_diff;
        if (!reset_reset_n) begin
            raw_dly = '{13'h0, 13'h0};
            syn_hist.delete();
            m_stable = '0; m_edge = '0; m_mask = '0; m_rdata = '0; m_irq = 1'b0;
        end else begin
            synced = raw_dly.pop_front();
            raw_dly.push_back({~ORG_BUTTON, SW});
            syn_hist.push_back(synced);
            if (syn_hist.size() > D) void'(syn_hist.pop_front());
            nxt = m_stable;
            for (int b = 0; b < 13; b++) begin
                all_diff = (syn_hist.size() == D);
                foreach (syn_hist[k]) if (syn_hist[k][b] == m_stable[b]) all_diff = 0;
                if (all_diff) nxt[b] = ~m_stable[b];
            end
            if (bus.avs_read) begin
                case (bus.avs_address)
                    2'd0: m_rdata = 32'(m_stable[9:0]) + (32'(m_stable[12:10]) << 16);
                    2'd1: m_rdata = 32'(m_edge);
                    2'd2: m_rdata = 32'(m_mask);
                    default: m_rdata = 32'h0DE0_0001;
                endcase
            end
            m_irq = (m_edge & m_mask) != 3'b0;
            pr = nxt[12:10] & ~m_stable[12:10];
            if (bus.avs_write && bus.avs_address == 2'd1) m_edge = m_edge & ~bus.avs_writedata[2:0];
            if (bus.avs_write && bus.avs_address == 2'd2) m_mask = bus.avs_writedata[2:0];
            m_edge   = m_edge | pr;
            m_stable = nxt;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        model_step();
        #1;
        check("irq_model", {31'b0, bus.irq}, {31'b0, m_irq});
        check("rdata_model", bus.avs_readdata, m_rdata);
        @(negedge clk_clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        tick();
        bus.avs_read    = 1'b0;
        d = bus.avs_readdata;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        tick();
        bus.avs_write     = 1'b0;
    endtask

    initial begin
        reset_reset_n     = 1'b0;
        ORG_BUTTON        = 3'b111;
        SW                = '0;
        bus.avs_address   = '0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
        @(negedge clk_clk);
        ticks(3);
        check("reset_irq", {31'b0, bus.irq}, 32'd0);
        check("reset_rdata", bus.avs_readdata, 32'd0);
        reset_reset_n = 1'b1;

        read_reg(2'd3, rd); check("id", rd, 32'h0DE0_0001);
        read_reg(2'd0, rd); check("status_idle", rd, 32'h0);

        // Glitch of exactly D-1 synchronised cycles must be rejected.
        SW[3] = 1'b1; ticks(3); SW[3] = 1'b0; ticks(8);
        read_reg(2'd0, rd); check("glitch_status", rd, 32'h0);

        SW[3] = 1'b1; ticks(5);
        read_reg(2'd0, rd); check("sw3_before", rd, 32'h0);
        read_reg(2'd0, rd); check("sw3_after", rd, 32'h8);
        SW[3] = 1'b0; ticks(8);
        read_reg(2'd0, rd); check("sw3_low", rd, 32'h0);

        ORG_BUTTON = 3'b101; ticks(8);
        read_reg(2'd0, rd); check("btn1_status", rd, 32'h0002_0000);
        read_reg(2'd1, rd); check("btn1_edge", rd, 32'h2);
        check("btn1_irq_masked", {31'b0, bus.irq}, 32'd0);
        write_reg(2'd2, 32'hFFFF_FFFA);
        check("mask_irq_same", {31'b0, bus.irq}, 32'd0);
        tick(); check("mask_irq_rise", {31'b0, bus.irq}, 32'd1);
        read_reg(2'd2, rd); check("mask_read", rd, 32'h2);

        write_reg(2'd1, 32'h2);
        check("w1c_irq_same", {31'b0, bus.irq}, 32'd1);
        tick(); check("w1c_irq_fall", {31'b0, bus.irq}, 32'd0);
        read_reg(2'd1, rd); check("w1c_edge", rd, 32'h0);

        ORG_BUTTON = 3'b111; ticks(5);
        read_reg(2'd0, rd); check("rel_before", rd, 32'h0002_0000);
        read_reg(2'd0, rd); check("rel_after", rd, 32'h0);
        read_reg(2'd1, rd); check("rel_no_edge", rd, 32'h0);

        // W1C on the very cycle button 0 debounces to pressed.
        write_reg(2'd2, 32'h1);
        ORG_BUTTON = 3'b110; ticks(5);
        write_reg(2'd1, 32'h1);
        read_reg(2'd1, rd); check("set_wins_edge", rd, 32'h1);
        check("set_wins_irq", {31'b0, bus.irq}, 32'd1);

        // Reset mid-debounce with SW[5] and button 0 still active.
        SW[5] = 1'b1; ticks(4);
        reset_reset_n = 1'b0; tick(); reset_reset_n = 1'b1;
        check("rst_irq", {31'b0, bus.irq}, 32'd0);
        ticks(5);
        read_reg(2'd0, rd); check("rst_status_before", rd, 32'h0);
        read_reg(2'd0, rd); check("rst_status_after", rd, 32'h0001_0020);
        read_reg(2'd1, rd); check("held_through_reset_edge", rd, 32'h1);
        read_reg(2'd2, rd); check("rst_mask", rd, 32'h0);

        write_reg(2'd2, 32'h7);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) SW[$urandom_range(0, 9)] ^= 1'b1;
            if ($urandom_range(0, 7) == 0) ORG_BUTTON[$urandom_range(0, 2)] ^= 1'b1;
            bus.avs_address   = 2'($urandom_range(0, 3));
            bus.avs_read      = ($urandom_range(0, 1) == 1);
            bus.avs_write     = ($urandom_range(0, 4) == 0);
            bus.avs_writedata = $urandom();
            reset_reset_n     = ($urandom_range(0, 249) != 0);
            tick();
        end
        bus.avs_read  = 1'b0;
        bus.avs_write = 1'b0;
        reset_reset_n = 1'b1;
        ticks(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
